// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, bus widths and pixel colour expansion.
// Defaults describe 640x480@60 scanned from a 320x240 3-bit frame buffer.
package vga_pkg;

  localparam int COLOR_BITS  = 3;
  localparam int CLK_DIV     = 2;
  localparam int SCALE_SHIFT = 1;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CNT_W   = 10;
  localparam int PIX_X_W = 9;
  localparam int PIX_Y_W = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // bit2 drives red, bit1 green, bit0 blue; each channel is fully on or off.
  function automatic rgb_t color_expand(input logic [2:0] pix);
    rgb_t c;
    c.r = {8{pix[2]}};
    c.g = {8{pix[1]}};
    c.b = {8{pix[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_scanner_if.sv
// Scanner bundle: frame-buffer read port (coordinates out, registered data in)
// plus the VGA output pins; master is the scanner, slave the memory/DAC side.
interface vga_frame_scanner_if #(
  parameter int COLOR_BITS = vga_pkg::COLOR_BITS
);
  import vga_pkg::*;

  logic [PIX_X_W-1:0]    pix_x;
  logic [PIX_Y_W-1:0]    pix_y;
  logic [COLOR_BITS-1:0] pix_value;
  logic [7:0]            vga_r;
  logic [7:0]            vga_g;
  logic [7:0]            vga_b;
  logic                  vga_hsync;
  logic                  vga_vsync;
  logic                  vga_blank_n;
  logic                  vga_clk;
  logic                  frame_start;

  modport master (
    output pix_x, pix_y,
    input  pix_value,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank_n, vga_clk, frame_start
  );

  modport slave (
    input  pix_x, pix_y,
    output pix_value,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank_n, vga_clk, frame_start
  );

endinterface

// File: rtl/vga_timing_counter.sv
// Pixel-tick divider and h/v raster counters; sync/visible decode is combinational from counters.
// Free-running, no backpressure; pix_clk and frame_wrap are registered.
module vga_timing_counter #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      tick,
  output logic [vga_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_pkg::CNT_W-1:0] v_cnt,
  output logic                      visible,
  output logic                      hsync_raw,
  output logic                      vsync_raw,
  output logic                      frame_wrap,
  output logic                      pix_clk
);
  import vga_pkg::*;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             h_last;
  logic             v_last;

  assign tick      = (div_cnt == DIV_LAST);
  assign div_next  = tick ? '0 : div_cnt + DIV_W'(1);
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hsync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vsync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pix_clk    <= 1'b0;
      frame_wrap <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      // high for the first half of every tick period, starting at div_cnt==0
      pix_clk    <= (div_next < DIV_HALF);
      frame_wrap <= tick && h_last && v_last;
      if (tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_frame_scanner.sv
// Raster-scans the frame buffer and drives VGA; every VGA output lags the scan counters by one pixel tick.
// No backpressure: one fire-and-forget read per tick, data expected one clk after the address.
module vga_frame_scanner #(
  parameter int COLOR_BITS  = vga_pkg::COLOR_BITS,
  parameter int CLK_DIV     = vga_pkg::CLK_DIV,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int H_VIS       = vga_pkg::H_VIS,
  parameter int H_FP        = vga_pkg::H_FP,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_BP        = vga_pkg::H_BP,
  parameter int V_VIS       = vga_pkg::V_VIS,
  parameter int V_FP        = vga_pkg::V_FP,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_BP        = vga_pkg::V_BP
) (
  input logic                 clk,
  input logic                 rst,
  vga_frame_scanner_if.master vga
);
  import vga_pkg::*;

  logic             tick;
  logic             visible;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             frame_wrap;
  logic             pix_clk;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic [COLOR_BITS-1:0] pix_in;
  rgb_t                  rgb_q;
  logic                  blank_n_q;
  logic                  hsync_q;
  logic                  vsync_q;

  vga_timing_counter #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .visible    (visible),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .frame_wrap (frame_wrap),
    .pix_clk    (pix_clk)
  );

  // Address parks at (0,0) during blanking so the memory never sees an out-of-range read.
  assign vga.pix_x = visible ? PIX_X_W'(h_cnt >> SCALE_SHIFT) : '0;
  assign vga.pix_y = visible ? PIX_Y_W'(v_cnt >> SCALE_SHIFT) : '0;
  assign pix_in    = vga.pix_value;

  // Captured on the tick that ends the counter period: read data, visibility and
  // sync all describe the same raster position, so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else if (tick) begin
      rgb_q     <= visible ? color_expand(pix_in[2:0]) : '0;
      blank_n_q <= visible;
      hsync_q   <= hsync_raw;
      vsync_q   <= vsync_raw;
    end
  end

  assign vga.vga_r       = rgb_q.r;
  assign vga.vga_g       = rgb_q.g;
  assign vga.vga_b       = rgb_q.b;
  assign vga.vga_blank_n = blank_n_q;
  assign vga.vga_hsync   = hsync_q;
  assign vga.vga_vsync   = vsync_q;
  assign vga.vga_clk     = pix_clk;
  assign vga.frame_start = frame_wrap;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench: a default-timing scanner and a shrunken-timing scanner (CLK_DIV=3) run side by side
// against a clk-count raster model, with a registered memory model holding random/patterned images.
module tb_vga_frame_scanner;

  typedef struct packed {
    int div;
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
  } tcfg_t;

  localparam tcfg_t CF = '{div: 2, hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33};
  localparam tcfg_t CS = '{div: 3, hv: 40, hf: 4, hs: 8, hb: 6, vv: 24, vf: 2, vs: 2, vb: 3};
  localparam logic [45:0] RST_VAL = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 8'h0};

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   k;
  int   mode;
  int   phase;
  int   fs_cnt;
  logic prev_v [4];
  int   last_fall [4];
  int   nfall [4];
  logic [2:0] mem [240][320];

  vga_frame_scanner_if #(.COLOR_BITS(3)) if_f ();
  vga_frame_scanner_if #(.COLOR_BITS(3)) if_s ();

  vga_frame_scanner dut_f (.clk(clk), .rst(rst), .vga(if_f));

  vga_frame_scanner #(
    .COLOR_BITS(3), .CLK_DIV(CS.div), .SCALE_SHIFT(1),
    .H_VIS(CS.hv), .H_FP(CS.hf), .H_SYNC(CS.hs), .H_BP(CS.hb),
    .V_VIS(CS.vv), .V_FP(CS.vf), .V_SYNC(CS.vs), .V_BP(CS.vb)
  ) dut_s (.clk(clk), .rst(rst), .vga(if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: random image, 1: all white, 2: green at column 0 rows 1..24
  function automatic logic [2:0] mem_rd(input int x, input int y);
    if (mode == 1) return 3'b111;
    if (mode == 2) return (x == 0 && y >= 1 && y <= 24) ? 3'b010 : 3'b000;
    if (x < 320 && y < 240) return mem[y][x];
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    if_f.pix_value <= mem_rd(int'(if_f.pix_x), int'(if_f.pix_y));
    if_s.pix_value <= mem_rd(int'(if_s.pix_x), int'(if_s.pix_y));
  end

  logic [45:0] obs_f;
  logic [45:0] obs_s;
  assign obs_f = {if_f.vga_r, if_f.vga_g, if_f.vga_b, if_f.vga_hsync, if_f.vga_vsync,
                  if_f.vga_blank_n, if_f.vga_clk, if_f.frame_start, if_f.pix_x, if_f.pix_y};
  assign obs_s = {if_s.vga_r, if_s.vga_g, if_s.vga_b, if_s.vga_hsync, if_s.vga_vsync,
                  if_s.vga_blank_n, if_s.vga_clk, if_s.frame_start, if_s.pix_x, if_s.pix_y};

  // Expected pins kk clks after reset release: counters sit at tick p = kk/div,
  // the output registers show the raster position one tick earlier.
  function automatic logic [45:0] model(input tcfg_t c, input int kk);
    int ht, vt, p, h, v, q, hq, vq;
    logic vis, visq, hs, vs, vc, fs;
    logic [2:0] pv;
    logic [23:0] rgb;
    logic [8:0] px;
    logic [7:0] py;
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    p   = kk / c.div;
    h   = p % ht;
    v   = (p / ht) % vt;
    vis = (h < c.hv) && (v < c.vv);
    px  = vis ? 9'(h / 2) : 9'd0;
    py  = vis ? 8'(v / 2) : 8'd0;
    vc  = (kk % c.div) < (c.div / 2);
    fs  = (kk % c.div == 0) && (p > 0) && (p % (ht * vt) == 0);
    rgb = 24'h0;
    hs  = 1'b1;
    vs  = 1'b1;
    visq = 1'b0;
    if (p > 0) begin
      q    = p - 1;
      hq   = q % ht;
      vq   = (q / ht) % vt;
      visq = (hq < c.hv) && (vq < c.vv);
      hs   = !(hq >= c.hv + c.hf && hq < c.hv + c.hf + c.hs);
      vs   = !(vq >= c.vv + c.vf && vq < c.vv + c.vf + c.vs);
      if (visq) begin
        pv  = mem_rd(hq / 2, vq / 2);
        rgb = {{8{pv[2]}}, {8{pv[1]}}, {8{pv[0]}}};
      end
    end
    return {rgb, hs, vs, visq, vc, fs, px, py};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at clk %0d: observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Sync pulse shape: first falling edge, low width and period, all in clks.
  task automatic track(input int id, input string tag, input logic val,
                       input int first_k, input int len, input int per);
    if (prev_v[id] && !val) begin
      if (last_fall[id] < 0) chk({tag, "_first_fall"}, k, first_k);
      else chk({tag, "_period"}, k - last_fall[id], per);
      last_fall[id] = k;
      nfall[id]++;
    end else if (!prev_v[id] && val && last_fall[id] >= 0) begin
      chk({tag, "_low_width"}, k - last_fall[id], len);
    end
    prev_v[id] = val;
  endtask

  task automatic release_rst();
    rst    = 1'b0;
    k      = 0;
    fs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      prev_v[i]    = 1'b1;
      last_fall[i] = -1;
      nfall[i]     = 0;
    end
  endtask

  task automatic assert_rst_midcycle(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_async_full"}, 64'(obs_f), 64'(RST_VAL));
    chk({tag, "_async_small"}, 64'(obs_s), 64'(RST_VAL));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_full"}, 64'(obs_f), 64'(RST_VAL));
      chk({tag, "_hold_small"}, 64'(obs_s), 64'(RST_VAL));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      chk("full_pins", 64'(obs_f), 64'(model(CF, k)));
      chk("small_pins", 64'(obs_s), 64'(model(CS, k)));
      track(0, "full_hsync", if_f.vga_hsync, 2 * (656 + 1), 2 * 96, 2 * 800);
      track(1, "full_vsync", if_f.vga_vsync, 2 * (490 * 800 + 1), 2 * 2 * 800, 2 * 420000);
      track(2, "small_hsync", if_s.vga_hsync, 3 * (44 + 1), 3 * 8, 3 * 58);
      track(3, "small_vsync", if_s.vga_vsync, 3 * (26 * 58 + 1), 3 * 2 * 58, 3 * 58 * 31);
      if (if_s.frame_start) fs_cnt++;
      if (phase == 1) begin
        case (k)
          4804, 4806: chk("addr_h2_h3_v3", {if_f.pix_x, if_f.pix_y}, {9'd1, 8'd1});
          4808, 4810: chk("addr_h4_h5_v3", {if_f.pix_x, if_f.pix_y}, {9'd2, 8'd1});
          6200:       chk("addr_h700_blank", {if_f.pix_x, if_f.pix_y}, {9'd0, 8'd0});
          default: ;
        endcase
      end else if (phase == 2) begin
        case (k)
          1602:       chk("green_row1_off", if_f.vga_g, 8'h00);
          3202, 3204: chk("green_row2_on", if_f.vga_g, 8'hFF);
          3206:       chk("green_row2_col2_off", if_f.vga_g, 8'h00);
          default: ;
        endcase
      end else if (phase == 3) begin
        case (k)
          1280: chk("white_last_visible", {if_f.vga_r, if_f.vga_g, if_f.vga_b, if_f.vga_blank_n}, {24'hFFFFFF, 1'b1});
          1282: chk("white_first_blank", {if_f.vga_r, if_f.vga_g, if_f.vga_b, if_f.vga_blank_n}, {24'h000000, 1'b0});
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    k      = 0;
    mode   = 0;
    phase  = 0;
    fs_cnt = 0;
    rst    = 1'b1;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        mem[y][x] = 3'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("por_full", 64'(obs_f), 64'(RST_VAL));
    chk("por_small", 64'(obs_s), 64'(RST_VAL));

    // random image, several lines of the full raster and two small frames
    phase = 1;
    release_rst();
    run(12000);
    chk("full_hsync_fall_count", nfall[0], 7);
    chk("small_vsync_fall_count", nfall[3], 2);
    chk("small_frame_start_count", fs_cnt, 2);

    // reset mid-frame, then a single green column pattern
    assert_rst_midcycle("rst1");
    phase = 2;
    mode  = 2;
    release_rst();
    run(8000);

    // reset mid-line, then an all-white image to expose blanking
    assert_rst_midcycle("rst2");
    phase = 3;
    mode  = 1;
    release_rst();
    run(8000);

    // fresh random image after one more reset
    assert_rst_midcycle("rst3");
    phase = 4;
    mode  = 0;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        mem[y][x] = 3'($urandom);
    release_rst();
    run(4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
